// File: rtl/uart_cmd_responder_if.sv
// uart_cmd_responder_if: byte-stream and register-port signals of the UART command responder
interface uart_cmd_responder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       frame_err;
  logic       timeout_err;
  logic       overrun_err;
  modport slave (
    input  rx_data, rx_valid, tx_full, reg_rdata,
    output tx_data, tx_wr, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_err, timeout_err, overrun_err
  );
  modport master (
    output rx_data, rx_valid, tx_full, reg_rdata,
    input  tx_data, tx_wr, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_err, timeout_err, overrun_err
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: parses host read/write frames, drives the register port, returns ACK/NAK responses
module uart_cmd_responder #(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h5A,
  parameter logic [7:0]  NAK_BYTE       = 8'hEE
) (
  input logic clk,
  input logic rst,
  uart_cmd_responder_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [3:0] {HUNT, CMD, ADDR, DATA, CHK, EXEC, RDWAIT, RESP0, RESP1} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [7:0] addr_q, wdata_q, chk, resp0, resp1;
  logic is_rd, two, in_frame, timeout, ok_cmd, acc;
  assign in_frame = state inside {CMD, ADDR, DATA, CHK};
  assign timeout  = in_frame && cnt == CW'(TIMEOUT_CYCLES);
  assign ok_cmd   = bus.rx_data == 8'h01 || bus.rx_data == 8'h02;
  assign acc      = bus.rx_valid && !timeout;
  assign bus.busy        = state != HUNT;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.reg_we      = state == EXEC && !is_rd;
  assign bus.reg_re      = state == EXEC && is_rd;
  assign bus.tx_wr       = (state == RESP0 || state == RESP1) && !bus.tx_full;
  assign bus.tx_data     = state == RESP1 ? resp1 : state == RESP0 ? resp0 : 8'h00;
  assign bus.frame_err   = acc && ((state == CMD && !ok_cmd) || (state == CHK && bus.rx_data != chk));
  assign bus.timeout_err = timeout;
  assign bus.overrun_err = bus.rx_valid && state inside {EXEC, RDWAIT, RESP0, RESP1};
  // state register and inter-byte idle counter, which only runs while a frame is open
  always_ff @(posedge clk) begin
    state <= rst ? HUNT : state_n;
    cnt   <= (rst || !in_frame || bus.rx_valid || timeout) ? '0 : cnt + 1'b1;
  end
  // next-state: a timeout overrides whatever byte arrives in the same cycle
  always_comb begin
    state_n = state;
    if (timeout) state_n = HUNT;
    else
      case (state)
        HUNT:    if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_n = CMD;
        CMD:     if (bus.rx_valid) state_n = ok_cmd ? ADDR : RESP0;
        ADDR:    if (bus.rx_valid) state_n = is_rd ? CHK : DATA;
        DATA:    if (bus.rx_valid) state_n = CHK;
        CHK:     if (bus.rx_valid) state_n = bus.rx_data == chk ? EXEC : RESP0;
        EXEC:    state_n = is_rd ? RDWAIT : RESP0;
        RDWAIT:  state_n = RESP0;
        RESP0:   if (!bus.tx_full) state_n = two ? RESP1 : HUNT;
        RESP1:   if (!bus.tx_full) state_n = HUNT;
        default: state_n = HUNT;
      endcase
  end
  // frame field latches, running checksum and response bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      chk     <= 8'h00;
      resp0   <= 8'h00;
      resp1   <= 8'h00;
      two     <= 1'b0;
      is_rd   <= 1'b0;
    end else if (state == CMD && acc) begin
      is_rd <= bus.rx_data == 8'h02;
      chk   <= bus.rx_data;
      resp0 <= NAK_BYTE;
      two   <= 1'b0;
    end else if (state == ADDR && acc) begin
      addr_q <= bus.rx_data;
      chk    <= chk ^ bus.rx_data;
    end else if (state == DATA && acc) begin
      wdata_q <= bus.rx_data;
      chk     <= chk ^ bus.rx_data;
    end else if (state == CHK && acc) begin
      resp0 <= NAK_BYTE;
      two   <= 1'b0;
    end else if (state == EXEC) begin
      resp0 <= ACK_BYTE;
      two   <= 1'b0;
    end else if (state == RDWAIT) begin
      resp0 <= ACK_BYTE;
      resp1 <= bus.reg_rdata;
      two   <= 1'b1;
    end
  end
endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Frame-level responder for the UART link: consumes received bytes from the UART core's receive path and parses command frames.
- Executes register reads and writes on a simple single-cycle register port.
- Pushes response bytes into the UART core's transmit path.
- Sits between uart_top's receive/transmit byte interfaces and the chip-test register space. It is the device end answering a host initiator.

Parameters:
- TIMEOUT_CYCLES, 100000: maximum idle clocks between bytes inside a frame before the frame is abandoned.
- SYNC_BYTE, 8'hA5: frame start marker.
- ACK_BYTE, 8'h5A: success response.
- NAK_BYTE, 8'hEE: failure response.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- tx_data  out  8  byte to transmit
- tx_wr  out  1  one-cycle write strobe into the transmit FIFO
- tx_full  in  1  transmit FIFO full; tx_wr is never asserted while high
- reg_addr  out  8  register address
- reg_wdata  out  8  register write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
- busy  out  1  high in any state other than HUNT
- frame_err  out  1  one-cycle pulse on bad command or checksum
- timeout_err  out  1  one-cycle pulse on inter-byte timeout
- overrun_err  out  1  one-cycle pulse when a byte arrives while it cannot be accepted

Behaviour:
- Clock and reset:
  - Single clock domain. All state is updated on posedge clk.
  - When rst is high at a clock edge, the state goes to HUNT.
  - All outputs reset to 0 (tx_data, reg_addr and reg_wdata to 8'h00), and the timeout counter is cleared.
  - rst asserted mid-frame or mid-response abandons the frame. No partial response is emitted after reset.
- Frame format (host to device):
  - Write: SYNC, CMD=8'h01, ADDR, DATA, CHK, where CHK = CMD^ADDR^DATA.
  - Read: SYNC, CMD=8'h02, ADDR, CHK, where CHK = CMD^ADDR.
- States: HUNT, CMD, ADDR, DATA, CHK, EXEC, RDWAIT, RESP0, RESP1.
- HUNT:
  - Non-SYNC bytes are discarded silently.
  - On rx_valid with rx_data==SYNC_BYTE, go to CMD.
- CMD:
  - 8'h01 or 8'h02: latch the command, go to ADDR.
  - Any other value, including SYNC: pulse frame_err, load NAK, go to RESP0.
- ADDR: latch the byte into reg_addr. Go to DATA for a write, CHK for a read.
- DATA: latch the byte into reg_wdata, go to CHK.
- CHK:
  - Compare the received byte against the running XOR.
  - Match: go to EXEC.
  - Mismatch: pulse frame_err, load NAK, go to RESP0. No register access occurs.
- EXEC:
  - Write: reg_we high for exactly 1 cycle, response = ACK only, go to RESP0.
  - Read: reg_re high for exactly 1 cycle, go to RDWAIT.
- RDWAIT: capture reg_rdata into the response data register. Response = ACK followed by the data byte. Go to RESP0.
- RESP0:
  - When tx_full is low: tx_data = first response byte, tx_wr = 1 for 1 cycle.
  - Then go to RESP1 if a second byte is pending, else HUNT.
  - While tx_full is high: hold state, tx_wr = 0.
- RESP1: same rule as RESP0 for the data byte, then go to HUNT.
- Latency: the register strobe is asserted 1 cycle after the CHK byte's rx_valid. The first tx_wr follows at the earliest:
  - write: 1 cycle after the reg_we cycle;
  - read: 2 cycles after the reg_re cycle.
- Timeout:
  - In CMD, ADDR, DATA or CHK, the counter increments on every cycle without rx_valid and clears on rx_valid.
  - When the counter reaches TIMEOUT_CYCLES: pulse timeout_err, return to HUNT, no response.
  - The counter is held at 0 in all other states.
  - Counter width is clog2(TIMEOUT_CYCLES+1) and it never wraps.
- Overrun: rx_valid in EXEC, RDWAIT, RESP0 or RESP1 drops the byte and pulses overrun_err. The state is unaffected.
- Strobe exclusivity: reg_we and reg_re are never high together. tx_wr is never high while tx_full is high.

Test Plan:
- Write: A5 01 10 3C 2D, one byte per 16 clks -> single reg_we with addr 8'h10, wdata 8'h3C; tx_wr once with 8'h5A; busy returns to 0.
- Read: A5 02 22 20 with reg_rdata=8'h9B -> reg_re once with addr 8'h22; tx_wr 8'h5A then 8'h9B.
- Bad frames:
  - A5 01 10 3C 00 -> frame_err pulse, no reg_we, tx 8'hEE.
  - A5 07 -> frame_err pulse immediately, tx 8'hEE, the next byte is parsed from HUNT.
- Noise then timeout:
  - 00 FF then A5 01, then silence for TIMEOUT_CYCLES (set to 50) -> timeout_err pulse on cycle 50, HUNT, no tx_wr.
  - A following valid read then succeeds.
- Backpressure: read frame with tx_full held high for 20 cycles -> tx_wr stays 0; when tx_full drops, tx_wr in consecutive eligible cycles carries 5A then data. A byte injected during the hold -> overrun_err pulse.
- Reset mid-frame: rst high for 1 cycle after A5 02 22 -> all outputs 0, busy 0, no reg_re, no tx_wr; a subsequent full read frame works.
